// File: rtl/gray_dec_pkg.sv
// rtl/gray_dec_pkg.sv - shared types and constants for the Gray-count decoder
package gray_dec_pkg;

   localparam int WIDTH_DEF  = 3;
   localparam int ERR_W_DEF  = 8;
   localparam int RELOCK_DEF = 2;

   // Legal deltas; DELTA_DN becomes all-ones once cast to the count width.
   localparam int DELTA_UP = 1;
   localparam int DELTA_DN = -1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational reflected-Gray to binary conversion
module gray_to_bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   assign bin[WIDTH-1] = gray[WIDTH-1];

   // Each binary bit is the XOR of all Gray bits from the MSB down to it.
   for (genvar i = 0; i < WIDTH - 1; i++) begin : g_prefix
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_count_decoder.sv
// rtl/gray_count_decoder.sv - Gray count stream checker: binary, direction, illegal-step tracking
// err_cnt register exists only when GRAY_DEC_ERR_CNT_EN is defined; otherwise err_cnt is 0.
module gray_count_decoder
   import gray_dec_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ERR_W  = ERR_W_DEF,
   parameter int RELOCK = RELOCK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [WIDTH-1:0] count_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             dir,
   output logic             hold,
   output logic             step_err,
   output logic             dir_flip,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int RC_W = (RELOCK < 1) ? 1 : $clog2(RELOCK + 1);

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] bin_q, bin_nxt;
   logic [WIDTH-1:0] sample_bin;
   logic [WIDTH-1:0] delta;
   logic [RC_W-1:0]  relock_q, relock_nxt;
   logic             dir_q, dir_nxt;
   logic             dir_known_q, dir_known_nxt;
   logic             hold_q, hold_nxt;
   logic             err_q, err_nxt;
   logic             flip_q, flip_nxt;
   logic             locked_q, locked_nxt;
   logic             is_up, is_dn, is_hold, legal;

   gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
      .gray (count_in),
      .bin  (sample_bin)
   );

   // bin_q doubles as the previous-sample reference and the bin_out register.
   assign delta   = sample_bin - bin_q;
   assign is_up   = (delta == WIDTH'(DELTA_UP));
   assign is_dn   = (delta == WIDTH'(DELTA_DN));
   assign is_hold = (delta == '0);
   assign legal   = is_up | is_dn;

   always_comb begin
      state_nxt     = state_q;
      bin_nxt       = bin_q;
      relock_nxt    = relock_q;
      dir_nxt       = dir_q;
      dir_known_nxt = dir_known_q;
      hold_nxt      = 1'b0;
      err_nxt       = 1'b0;
      flip_nxt      = 1'b0;
      if (valid) begin
         bin_nxt = sample_bin;
         case (state_q)
            IDLE: begin
               state_nxt     = TRACK;
               dir_known_nxt = 1'b0;
            end
            TRACK: begin
               if (legal) begin
                  dir_nxt       = is_up;
                  flip_nxt      = dir_known_q && (is_up != dir_q);
                  dir_known_nxt = 1'b1;
               end else if (is_hold) begin
                  hold_nxt = 1'b1;
               end else begin
                  err_nxt       = 1'b1;
                  state_nxt     = FAULT;
                  relock_nxt    = '0;
                  dir_known_nxt = 1'b0;
               end
            end
            FAULT: begin
               if (legal) begin
                  dir_nxt = is_up;
                  if (int'(relock_q) + 1 >= RELOCK) begin
                     state_nxt  = TRACK;
                     relock_nxt = '0;
                  end else begin
                     relock_nxt = relock_q + RC_W'(1);
                  end
               end else if (is_hold) begin
                  hold_nxt = 1'b1;
               end else begin
                  err_nxt    = 1'b1;
                  relock_nxt = '0;
               end
            end
            default: begin
               state_nxt  = IDLE;
               relock_nxt = '0;
            end
         endcase
      end
      locked_nxt = (state_nxt == TRACK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         relock_q    <= '0;
         dir_q       <= 1'b0;
         dir_known_q <= 1'b0;
         hold_q      <= 1'b0;
         err_q       <= 1'b0;
         flip_q      <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         bin_q       <= bin_nxt;
         relock_q    <= relock_nxt;
         dir_q       <= dir_nxt;
         dir_known_q <= dir_known_nxt;
         hold_q      <= hold_nxt;
         err_q       <= err_nxt;
         flip_q      <= flip_nxt;
         locked_q    <= locked_nxt;
      end
   end

`ifdef GRAY_DEC_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (err_nxt && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

   assign bin_out  = bin_q;
   assign dir      = dir_q;
   assign hold     = hold_q;
   assign step_err = err_q;
   assign dir_flip = flip_q;
   assign locked   = locked_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// tb/tb_gray_count_decoder.sv - directed and randomized checks of gray_count_decoder against a reference model
module tb_gray_count_decoder;

   localparam int W  = 3;
   localparam int N  = 1 << W;
   localparam int EW = 2;
   localparam int RL = 2;
`ifdef GRAY_DEC_ERR_CNT_EN
   localparam bit EN_ERR = 1'b1;
`else
   localparam bit EN_ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid = 1'b0;
   logic [W-1:0]  count_in = '0;
   logic [W-1:0]  bin_out;
   logic          dir, hold, step_err, dir_flip, locked;
   logic [EW-1:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model, expressed with integers and the decoder's documented rules.
   int m_bin, m_relock, m_err;
   bit m_dir, m_started, m_locked, m_dir_known;
   bit m_hold, m_serr, m_flip;

   gray_count_decoder #(.WIDTH(W), .ERR_W(EW), .RELOCK(RL)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .count_in (count_in),
      .bin_out  (bin_out),
      .dir      (dir),
      .hold     (hold),
      .step_err (step_err),
      .dir_flip (dir_flip),
      .locked   (locked),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic int b2g(int b);
      return (b ^ (b >> 1)) % N;
   endfunction

   function automatic int g2b(int g);
      for (int v = 0; v < N; v++) begin
         if (b2g(v) == g) return v;
      end
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(bit r, bit v, int g);
      int b, d;
      bit up;
      m_hold = 0;
      m_serr = 0;
      m_flip = 0;
      if (r) begin
         m_bin = 0; m_dir = 0; m_started = 0; m_locked = 0;
         m_relock = 0; m_err = 0; m_dir_known = 0;
         return;
      end
      if (!v) return;
      b = g2b(g);
      if (!m_started) begin
         m_started = 1;
         m_locked = 1;
         m_dir_known = 0;
         m_bin = b;
         return;
      end
      d = (b - m_bin + N) % N;
      m_bin = b;
      if (d == 1 || d == N - 1) begin
         up = (d == 1);
         if (m_locked) begin
            m_flip = m_dir_known && (up != m_dir);
            m_dir_known = 1;
         end else begin
            m_relock++;
            if (m_relock == RL) begin
               m_locked = 1;
               m_relock = 0;
            end
         end
         m_dir = up;
      end else if (d == 0) begin
         m_hold = 1;
      end else begin
         m_serr = 1;
         if (EN_ERR && m_err < (1 << EW) - 1) m_err++;
         m_locked = 0;
         m_relock = 0;
         m_dir_known = 0;
      end
   endtask

   task automatic check_all();
      chk("bin_out", bin_out, m_bin);
      chk("dir", dir, m_dir);
      chk("hold", hold, m_hold);
      chk("step_err", step_err, m_serr);
      chk("dir_flip", dir_flip, m_flip);
      chk("locked", locked, m_started && m_locked);
      chk("err_cnt", err_cnt, m_err);
   endtask

   task automatic step(bit r, bit v, int g);
      reset = r;
      valid = v;
      count_in = W'(g);
      @(posedge clk);
      #1;
      model_step(r, v, g);
      check_all();
   endtask

   int asc_g[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
   int dsc_g[4] = '{0, 4, 5, 7};
   int dsc_b[4] = '{0, 7, 6, 5};

   initial begin
      // Reset state
      step(1, 0, 0);
      step(1, 1, 3);
      chk("rst_bin", bin_out, 0);
      chk("rst_locked", locked, 0);

      // Ascending Gray sequence with wrap 7 -> 0
      for (int i = 0; i < 9; i++) begin
         step(0, 1, asc_g[i]);
         chk("asc_bin", bin_out, i % N);
         chk("asc_err", step_err, 0);
      end
      chk("asc_dir", dir, 1);
      chk("asc_locked", locked, 1);

      // Descending with wrap 0 -> 7
      step(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, dsc_g[i]);
         chk("dsc_bin", bin_out, dsc_b[i]);
         chk("dsc_flip", dir_flip, 0);
      end
      chk("dsc_dir", dir, 0);

      // Direction flip and hold
      step(1, 0, 0);
      step(0, 1, 3);
      step(0, 1, 2);
      chk("flip_up_dir", dir, 1);
      chk("flip_first", dir_flip, 0);
      step(0, 1, 3);
      chk("flip_dn_dir", dir, 0);
      chk("flip_pulse", dir_flip, 1);
      step(0, 1, 3);
      chk("hold_pulse", hold, 1);
      chk("hold_dir", dir, 0);
      chk("hold_noflip", dir_flip, 0);

      // Single-bit Gray change that is an illegal step, then relock
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 2);
      chk("ill_err", step_err, 1);
      chk("ill_locked", locked, 0);
      chk("ill_cnt", err_cnt, EN_ERR ? 1 : 0);
      step(0, 1, 6);
      chk("relock1", locked, 0);
      step(0, 1, 7);
      chk("relock2", locked, 1);

      // Valid low freezes everything
      step(0, 0, 0);
      chk("idle_bin", bin_out, 5);
      chk("idle_locked", locked, 1);

      // Error counter saturation
      step(1, 0, 0);
      step(0, 1, b2g(0));
      for (int i = 0; i < 5; i++) step(0, 1, b2g((i % 2 == 0) ? 4 : 0));
      chk("sat_cnt", err_cnt, EN_ERR ? 3 : 0);
      chk("sat_err", step_err, 1);

      // Reset in FAULT with a simultaneous sample, then first sample again
      step(1, 1, 5);
      chk("rf_bin", bin_out, 0);
      chk("rf_locked", locked, 0);
      chk("rf_cnt", err_cnt, 0);
      step(0, 1, 1);
      chk("rf_first_bin", bin_out, 1);
      chk("rf_first_err", step_err, 0);

      // Randomized traffic, biased towards legal steps
      for (int i = 0; i < 500; i++) begin
         bit r, v;
         int d;
         r = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: d = 0;
            1, 2: d = 1;
            3, 4: d = N - 1;
            default: d = int'($urandom_range(0, N - 1));
         endcase
         step(r, v, b2g((m_bin + d) % N));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
